// File: rtl/multi_cycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core. One shared memory port,
// ALU and PC adder are reused across the cycles of each instruction. The
// sequencer stalls on mem_ready, enters a sticky FAULT state when a memory
// wait exceeds TIMEOUT_CYCLES, and counts retired instructions.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC; PC+4 written with the instruction
// DECODE   | compute branch/jump target (oldPC + imm); dispatch on op
// MEMADR   | compute load/store address (rs1 + imm)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd; retire
// MEMWRITE | write data memory at ALUOut; retire on mem_ready
// EXECR    | ALU on rs1, rs2 (funct-decoded)
// EXECI    | ALU on rs1, imm (funct-decoded)
// ALUWB    | write ALUOut to rd; retire
// JAL      | rd <- PC+4 via ALU; PC <- target held in ALUOut
// BEQ      | compare rs1, rs2; PC <- target when zero; retire
// FAULT    | unknown op or memory timeout; left only by reset
module multi_cycle_ctrl_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic [3:0]       state_o,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             fault
);

   localparam int unsigned WAIT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned WAIT_W     = (WAIT_W_RAW == 0) ? 1 : WAIT_W_RAW;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              timeout_hit;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

   assign state_o = state;

   // Limit cycle: wait_cnt has reached the limit and memory is still not ready.
   // A ready on that same cycle completes the access normally.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LIMIT) && !mem_ready;

   // Next state and Moore outputs (plus ready/zero gating); reset forces outputs low.
   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      instr_done = 1'b0;
      fault      = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready)        state_nxt = S_DECODE;
            else if (timeout_hit) state_nxt = S_FAULT;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_RTYPE:          state_nxt = S_EXECR;
               OP_ITYPE:          state_nxt = S_EXECI;
               OP_JAL:            state_nxt = S_JAL;
               OP_BEQ:            state_nxt = S_BEQ;
               default:           state_nxt = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready)        state_nxt = S_MEMWB;
            else if (timeout_hit) state_nxt = S_FAULT;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready)        state_nxt = S_FETCH;
            else if (timeout_hit) state_nxt = S_FAULT;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_nxt = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_nxt = S_FAULT;
         end
      endcase

      if (!rst) begin
         state_nxt  = S_FETCH;
         mem_req    = 1'b0;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         result_src = 2'b00;
         instr_done = 1'b0;
         fault      = 1'b0;
      end
   end

   // Wait counter: restarts on entry to a memory state and on each completed
   // access, counts stalled cycles otherwise, and saturates when timeout is off.
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (!is_mem_state(state_nxt) || (state_nxt != state) || mem_ready)
         wait_cnt_nxt = '0;
      else if (wait_cnt != {WAIT_W{1'b1}})
         wait_cnt_nxt = wait_cnt + 1'b1;
   end

   // State, wait counter and retired-instruction counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_FETCH;
         wait_cnt    <= '0;
         retired_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (instr_done)
            retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Directed bench for the multi-cycle control sequencer.
module tb_multi_cycle_ctrl_fsm;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  op;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic [3:0]  state_o;
   logic        instr_done;
   logic [31:0] retired_cnt;
   logic        fault;
   logic [13:0] ctl;

   int n_chk  = 0;
   int n_pass = 0;

   multi_cycle_ctrl_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .adr_src     (adr_src),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .result_src  (result_src),
      .state_o     (state_o),
      .instr_done  (instr_done),
      .retired_cnt (retired_cnt),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   assign ctl = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // Expected control vector per state:
   // {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, a, b, alu_op, result_src}
   function automatic logic [13:0] exp_ctl(input int st, input logic rdy, input logic z);
      case (st)
         0:  return {1'b1, 1'b0, rdy,  rdy,  1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
         1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
         2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
         3:  return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
         4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01};
         5:  return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
         6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
         7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
         8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00};
         9:  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
         10: return {1'b0, 1'b0, 1'b0, z,    1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00};
         default: return '0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction with mem_ready tied high; seq holds the expected
   // state trace, one nibble per cycle, first state in the low nibble.
   task automatic run_instr(input string name, input logic [6:0] opc, input logic z,
                            input logic [23:0] seq, input int len);
      logic [3:0] st;
      op        = opc;
      zero      = z;
      mem_ready = 1'b1;
      for (int i = 0; i < len; i++) begin
         #1;
         st = seq[4*i +: 4];
         chk({name, "_state"}, 32'(state_o), 32'(st));
         chk({name, "_ctl"}, 32'(ctl), 32'(exp_ctl(int'(st), 1'b1, z)));
         chk({name, "_done"}, 32'(instr_done), (i == len - 1) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   initial begin
      rst       = 1'b0;
      op        = 7'b0;
      zero      = 1'b0;
      mem_ready = 1'b1;

      // T1: reset
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rst_ctl", 32'(ctl), 32'd0);
         chk("rst_done", 32'(instr_done), 32'd0);
         tick();
         chk("rst_state", 32'(state_o), 32'd0);
      end
      rst = 1'b1;
      #1;
      chk("post_rst_ir_write", 32'(ir_write), 32'd1);
      chk("post_rst_pc_write", 32'(pc_write), 32'd1);
      chk("post_rst_retired", retired_cnt, 32'd0);
      chk("post_rst_fault", 32'(fault), 32'd0);

      // T2: lw, sw, add, addi, jal, beq(zero=1)
      run_instr("lw",   OP_LW,   1'b0, 24'h043210, 5);
      run_instr("sw",   OP_SW,   1'b0, 24'h005210, 4);
      run_instr("add",  OP_ADD,  1'b0, 24'h007610, 4);
      run_instr("addi", OP_ADDI, 1'b0, 24'h007810, 4);
      run_instr("jal",  OP_JAL,  1'b0, 24'h007910, 4);
      run_instr("beq1", OP_BEQ,  1'b1, 24'h000A10, 3);
      chk("t2_retired", retired_cnt, 32'd6);

      // T3: beq not taken
      run_instr("beq0", OP_BEQ, 1'b0, 24'h000A10, 3);
      chk("t3_state", 32'(state_o), 32'd0);
      chk("t3_retired", retired_cnt, 32'd7);

      // T4: sw stalled 5 cycles in MEMWRITE
      op = OP_SW;
      mem_ready = 1'b1;
      #1;
      chk("t4_fetch", 32'(state_o), 32'd0);
      tick();
      chk("t4_decode", 32'(state_o), 32'd1);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("t4_memadr", 32'(state_o), 32'd2);
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_wait_state", 32'(state_o), 32'd5);
         chk("t4_wait_mem_write", 32'(mem_write), 32'd1);
         chk("t4_wait_done", 32'(instr_done), 32'd0);
         chk("t4_wait_fault", 32'(fault), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("t4_ready_mem_write", 32'(mem_write), 32'd1);
      chk("t4_ready_done", 32'(instr_done), 32'd1);
      tick();
      chk("t4_back_fetch", 32'(state_o), 32'd0);
      chk("t4_retired", retired_cnt, 32'd8);
      chk("t4_fault", 32'(fault), 32'd0);

      // T5a: ready arrives on the limit cycle -> no fault
      op = OP_ADDI;
      mem_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("t5a_wait_state", 32'(state_o), 32'd0);
         chk("t5a_wait_ctl", 32'(ctl), 32'(exp_ctl(0, 1'b0, 1'b0)));
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("t5a_limit_ir_write", 32'(ir_write), 32'd1);
      tick();
      chk("t5a_decode", 32'(state_o), 32'd1);
      chk("t5a_fault", 32'(fault), 32'd0);
      tick();
      tick();
      tick();
      chk("t5a_fetch", 32'(state_o), 32'd0);
      chk("t5a_retired", retired_cnt, 32'd9);

      // T5b: ready never comes -> FAULT
      mem_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         #1;
         chk("t5b_wait_state", 32'(state_o), 32'd0);
         chk("t5b_wait_fault", 32'(fault), 32'd0);
         tick();
      end
      chk("t5b_state", 32'(state_o), 32'd11);
      chk("t5b_fault", 32'(fault), 32'd1);
      chk("t5b_ctl", 32'(ctl), 32'd0);
      mem_ready = 1'b1;
      tick();
      chk("t5b_sticky", 32'(state_o), 32'd11);
      rst = 1'b0;
      #1;
      chk("t5b_rst_ctl", 32'(ctl), 32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("t5b_rst_state", 32'(state_o), 32'd0);
      chk("t5b_rst_fault", 32'(fault), 32'd0);
      chk("t5b_rst_retired", retired_cnt, 32'd0);

      run_instr("beq_pre_t6", OP_BEQ, 1'b0, 24'h000A10, 3);
      chk("pre_t6_retired", retired_cnt, 32'd1);

      // T6: illegal op -> sticky FAULT; reset clears
      op = 7'b0000000;
      mem_ready = 1'b1;
      #1;
      chk("t6_fetch", 32'(state_o), 32'd0);
      tick();
      chk("t6_decode", 32'(state_o), 32'd1);
      tick();
      chk("t6_fault_state", 32'(state_o), 32'd11);
      chk("t6_fault", 32'(fault), 32'd1);
      for (int k = 0; k < 4; k++) begin
         mem_ready = k[0];
         tick();
         chk("t6_sticky_state", 32'(state_o), 32'd11);
         chk("t6_sticky_fault", 32'(fault), 32'd1);
         chk("t6_sticky_ctl", 32'(ctl), 32'd0);
      end
      mem_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("t6_rst_ctl", 32'(ctl), 32'd0);
      chk("t6_rst_done", 32'(instr_done), 32'd0);
      tick();
      chk("t6_rst_state", 32'(state_o), 32'd0);
      chk("t6_rst_retired", retired_cnt, 32'd0);
      chk("t6_rst_fault", 32'(fault), 32'd0);
      rst = 1'b1;
      #1;
      chk("t6_post_ir_write", 32'(ir_write), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
